// File: rtl/ks12_pipelined_subtractor.sv
// 12-bit Kogge-Stone subtractor D = A - B, four registered stages under a valid/ready handshake.
// Define KS_SUB_OVF_EN to add the signed-overflow output Ovf and its sign-bit pipeline.
module ks12_pipelined_subtractor (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] A,
    input  logic [11:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] D,
    output logic        Bo
`ifdef KS_SUB_OVF_EN
    ,
    output logic        Ovf
`endif
);

    logic v1_q, v2_q, v3_q, v4_q;
    logic v1_d, v2_d, v3_d, v4_d;
    logic adv1, adv2, adv3, adv4;
    logic inXfer;

    // S1: entry propagate/generate (B complemented)
    logic [11:0] p1_q, g1_q;
    logic [11:0] pEntry, gEntry;

    // S2: original propagate plus 13-bit group vectors after spans 1 and 2
    logic [11:0] p0s2_q;
    logic [12:0] g2_q, pp2_q;
    logic [12:0] g2_d, pp2_d;

    // S3: original propagate plus fully resolved group generates
    logic [11:0] p0s3_q;
    logic [12:0] g3_q;
    logic [12:0] g3_d;

    // S4: result registers driving the outputs
    logic [11:0] d4_q, d4_d;
    logic        bo4_q, bo4_d;

    // Handshake chain: a stage moves on when it holds data and its successor is free or moving.
    assign adv4     = v4_q & out_ready;
    assign adv3     = v3_q & (~v4_q | adv4);
    assign adv2     = v2_q & (~v3_q | adv3);
    assign adv1     = v1_q & (~v2_q | adv2);
    assign in_ready = ~v1_q | adv1;
    assign inXfer   = in_valid & in_ready;

    assign v1_d = inXfer ? 1'b1 : (adv1 ? 1'b0 : v1_q);
    assign v2_d = adv1   ? 1'b1 : (adv2 ? 1'b0 : v2_q);
    assign v3_d = adv2   ? 1'b1 : (adv3 ? 1'b0 : v3_q);
    assign v4_d = adv3   ? 1'b1 : (adv4 ? 1'b0 : v4_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            v4_q <= v4_d;
        end
    end

    assign pEntry = A ^ ~B;
    assign gEntry = A & ~B;

    // Bit 0 of the 13-bit vectors is position -1: the carry-in as a pure generate with zero propagate.
    always_comb begin
        logic [12:0] gx, px, gl1, pl1;
        gx    = {g1_q, 1'b1};
        px    = {p1_q, 1'b0};
        gl1   = gx | (px & (gx << 1));
        pl1   = px & (px << 1);
        g2_d  = gl1 | (pl1 & (gl1 << 2));
        pp2_d = pl1 & (pl1 << 2);
    end

    always_comb begin
        logic [12:0] gl3, pl3;
        gl3  = g2_q | (pp2_q & (g2_q << 4));
        pl3  = pp2_q & (pp2_q << 4);
        g3_d = gl3 | (pl3 & (gl3 << 8));
    end

    assign d4_d  = p0s3_q ^ g3_q[11:0];
    assign bo4_d = ~g3_q[12];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_q   <= '0;
            g1_q   <= '0;
            p0s2_q <= '0;
            g2_q   <= '0;
            pp2_q  <= '0;
            p0s3_q <= '0;
            g3_q   <= '0;
            d4_q   <= '0;
            bo4_q  <= 1'b0;
        end else begin
            if (inXfer) begin
                p1_q <= pEntry;
                g1_q <= gEntry;
            end
            if (adv1) begin
                p0s2_q <= p1_q;
                g2_q   <= g2_d;
                pp2_q  <= pp2_d;
            end
            if (adv2) begin
                p0s3_q <= p0s2_q;
                g3_q   <= g3_d;
            end
            if (adv3) begin
                d4_q  <= d4_d;
                bo4_q <= bo4_d;
            end
        end
    end

    assign out_valid = v4_q;
    assign D         = d4_q;
    assign Bo        = bo4_q;

`ifdef KS_SUB_OVF_EN
    logic a1_q, b1_q, a2_q, b2_q, a3_q, b3_q, ovf4_q;
    logic ovf4_d;

    assign ovf4_d = (a3_q ^ b3_q) & (d4_d[11] ^ a3_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_q   <= 1'b0;
            b1_q   <= 1'b0;
            a2_q   <= 1'b0;
            b2_q   <= 1'b0;
            a3_q   <= 1'b0;
            b3_q   <= 1'b0;
            ovf4_q <= 1'b0;
        end else begin
            if (inXfer) begin
                a1_q <= A[11];
                b1_q <= B[11];
            end
            if (adv1) begin
                a2_q <= a1_q;
                b2_q <= b1_q;
            end
            if (adv2) begin
                a3_q <= a2_q;
                b3_q <= b2_q;
            end
            if (adv3) begin
                ovf4_q <= ovf4_d;
            end
        end
    end

    assign Ovf = ovf4_q;
`endif

endmodule
